// File: rtl/detect_event_logger_if.sv
// ----------------------------------------------------------------------------
// detect_event_logger_if
//   Bundles the detector/host-facing signals of detect_event_logger.
//   master : drives detect, clr, rd_en; observes the FIFO head and status.
//   slave  : the logger itself.
// Signals:
//   detect    detector output, one bit per serial bit-time
//   clr       synchronous soft clear (FIFO, event count, overflow)
//   rd_en     pop request for the FIFO head
//   rd_data   FIFO head timestamp (first-word-fall-through), 0 when empty
//   rd_valid  FIFO not empty
//   full      FIFO holds DEPTH entries
//   evt_count saturating count of detections (stored or dropped)
//   overflow  sticky, a detection was dropped on a full FIFO
// ----------------------------------------------------------------------------
interface detect_event_logger_if #(
    parameter int TS_W  = 8,
    parameter int CNT_W = 8
);
    logic             detect;
    logic             clr;
    logic             rd_en;
    logic [TS_W-1:0]  rd_data;
    logic             rd_valid;
    logic             full;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;

    modport master (
        output detect, clr, rd_en,
        input  rd_data, rd_valid, full, evt_count, overflow
    );

    modport slave (
        input  detect, clr, rd_en,
        output rd_data, rd_valid, full, evt_count, overflow
    );
endinterface

// File: rtl/detect_event_logger.sv
// ----------------------------------------------------------------------------
// detect_event_logger
//   Timestamps each detection of a serial sequence detector against a
//   free-running bit-time counter and queues the timestamps in a small
//   first-word-fall-through FIFO. Also keeps a saturating event count and a
//   sticky overflow flag.
// Ports:
//   clk_i  rising-edge clock, one serial bit per cycle
//   rst_i  synchronous active-high reset, clears all state
//   bus    detect_event_logger_if.slave (detect/clr/rd_en in, FIFO status out)
// Parameters:
//   TS_W   timestamp / FIFO data width
//   DEPTH  FIFO entries, power of two, >= 2
//   CNT_W  event counter width
// Build option:
//   DETECT_EDGE_EN  when defined, only the rising edge of detect is an event,
//                   so a run of detect=1 cycles logs one timestamp.
// ----------------------------------------------------------------------------
module detect_event_logger #(
    parameter int TS_W  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    detect_event_logger_if.slave    bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] evt_q, evt_d;
    logic             ovf_q, ovf_d;

    logic ev;
    logic do_push;
    logic do_pop;
    logic is_full;
    logic is_empty;

`ifdef DETECT_EDGE_EN
    logic detect_q, detect_d;
    assign ev       = bus.detect & ~detect_q;
    assign detect_d = bus.clr ? 1'b0 : bus.detect;
`else
    assign ev = bus.detect;
`endif

    assign is_full  = (occ_q == OCC_FULL);
    assign is_empty = (occ_q == '0);

    always_comb begin
        ts_d     = ts_q + 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        evt_d    = evt_q;
        ovf_d    = ovf_q;
        do_pop   = 1'b0;
        do_push  = 1'b0;

        if (bus.clr) begin
            // Soft clear empties the FIFO and swallows a same-edge event;
            // the timestamp keeps running so later stamps stay bit-accurate.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            evt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            do_pop  = bus.rd_en & ~is_empty;
            // A pop on a full FIFO frees the slot the write needs this edge.
            do_push = ev & (~is_full | do_pop);

            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;

            if (do_push && !do_pop)      occ_d = occ_q + 1'b1;
            else if (do_pop && !do_push) occ_d = occ_q - 1'b1;

            if (ev && !do_push) ovf_d = 1'b1;
            if (ev && evt_q != '1) evt_d = evt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            evt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            evt_q    <= evt_d;
            ovf_q    <= ovf_d;
            // Stored stamp is the pre-increment ts: index of the completing bit.
            if (do_push) mem_q[wr_ptr_q] <= ts_q;
        end
    end

`ifdef DETECT_EDGE_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) detect_q <= 1'b0;
        else       detect_q <= detect_d;
    end
`endif

    // All outputs come from registers; stale head data is masked when empty.
    assign bus.rd_data   = is_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.rd_valid  = ~is_empty;
    assign bus.full      = is_full;
    assign bus.evt_count = evt_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_detect_event_logger.sv
module tb_detect_event_logger;
    localparam int TS_W  = 8;
    localparam int CNT_W = 8;

`ifdef DETECT_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [TS_W-1:0] tb_ts = '0;   // model of the bit-time counter
    int   n_chk = 0;
    int   n_err = 0;

    detect_event_logger_if #(.TS_W(TS_W), .CNT_W(CNT_W)) bus ();

    detect_event_logger #(.TS_W(TS_W), .DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 1'b1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock; inputs and samples move 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ts(input int t);
        int n = 0;
        while (int'(tb_ts) != t && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("wait_ts_timeout", int'(tb_ts), t);
    endtask

    task automatic pulse();
        bus.detect = 1'b1;
        step();
        bus.detect = 1'b0;
    endtask

    task automatic soft_clr();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input int exp);
        chk({tag, "_valid"}, int'(bus.rd_valid), 1);
        chk({tag, "_data"}, int'(bus.rd_data), exp);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        int t;
        int exp_evt;
        bus.detect = 1'b0;
        bus.clr    = 1'b0;
        bus.rd_en  = 1'b0;

        // Reset, then idle
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        chk("rst_valid", int'(bus.rd_valid), 0);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_evt", int'(bus.evt_count), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_data", int'(bus.rd_data), 0);

        // Single event at ts=10
        wait_ts(10);
        pulse();
        chk("single_valid", int'(bus.rd_valid), 1);
        chk("single_data", int'(bus.rd_data), 10);
        chk("single_evt", int'(bus.evt_count), 1);
        bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
        chk("single_empty", int'(bus.rd_valid), 0);
        chk("single_empty_data", int'(bus.rd_data), 0);
        // Pop on empty is ignored
        bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
        chk("empty_pop_valid", int'(bus.rd_valid), 0);

        // Fill and overflow
        soft_clr();
        wait_ts(3); pulse();
        wait_ts(5); pulse();
        wait_ts(7); pulse();
        chk("fill3_full", int'(bus.full), 0);
        wait_ts(9); pulse();
        chk("fill4_full", int'(bus.full), 1);
        chk("fill4_ovf", int'(bus.overflow), 0);
        wait_ts(11); pulse();
        chk("drop_ovf", int'(bus.overflow), 1);
        chk("drop_evt", int'(bus.evt_count), 5);
        chk("drop_full", int'(bus.full), 1);
        pop_chk("drain0", 3);
        chk("drain_notfull", int'(bus.full), 0);
        pop_chk("drain1", 5);
        pop_chk("drain2", 7);
        pop_chk("drain3", 9);
        chk("drain_empty", int'(bus.rd_valid), 0);
        chk("drain_ovf_sticky", int'(bus.overflow), 1);

        // Full with simultaneous read and write
        soft_clr();
        chk("clr_ovf", int'(bus.overflow), 0);
        wait_ts(3); pulse();
        wait_ts(5); pulse();
        wait_ts(7); pulse();
        wait_ts(9); pulse();
        wait_ts(20);
        bus.detect = 1'b1; bus.rd_en = 1'b1;
        step();
        bus.detect = 1'b0; bus.rd_en = 1'b0;
        chk("rw_full", int'(bus.full), 1);
        chk("rw_ovf", int'(bus.overflow), 0);
        chk("rw_evt", int'(bus.evt_count), 5);
        pop_chk("rw0", 5);
        pop_chk("rw1", 7);
        pop_chk("rw2", 9);
        pop_chk("rw3", 20);
        chk("rw_empty", int'(bus.rd_valid), 0);

        // Timestamp wrap (edge mode needs a low cycle between events)
        soft_clr();
        wait_ts(255); pulse();
        if (EDGE) step();
        t = int'(tb_ts);
        pulse();
        pop_chk("wrap0", 255);
        pop_chk("wrap1", t);
        chk("wrap_t", t, EDGE ? 1 : 0);

        // Overflow, then clear with a same-edge detect
        repeat (5) begin
            pulse();
            step();
        end
        chk("pre_clr_ovf", int'(bus.overflow), 1);
        chk("pre_clr_evt", int'(bus.evt_count), 7);
        bus.clr = 1'b1; bus.detect = 1'b1;
        step();
        bus.clr = 1'b0; bus.detect = 1'b0;
        chk("clr_valid", int'(bus.rd_valid), 0);
        chk("clr_full", int'(bus.full), 0);
        chk("clr_evt", int'(bus.evt_count), 0);
        chk("clr_ovf2", int'(bus.overflow), 0);
        step();
        t = int'(tb_ts);
        pulse();
        chk("post_clr_ts", int'(bus.rd_data), t);
        chk("post_clr_evt", int'(bus.evt_count), 1);

        // Held detect: edge vs level qualification
        soft_clr();
        wait_ts(40);
        bus.detect = 1'b1;
        repeat (3) step();
        bus.detect = 1'b0;
        step();
        exp_evt = EDGE ? 1 : 3;
        chk("held_evt", int'(bus.evt_count), exp_evt);
        pop_chk("held0", 40);
        if (!EDGE) begin
            pop_chk("held1", 41);
            pop_chk("held2", 42);
        end
        chk("held_empty", int'(bus.rd_valid), 0);

        // Reset wins over detect and clears a non-empty FIFO
        pulse();
        pulse();
        rst = 1'b1; bus.detect = 1'b1; bus.rd_en = 1'b1;
        step();
        rst = 1'b0; bus.detect = 1'b0; bus.rd_en = 1'b0;
        chk("rst2_valid", int'(bus.rd_valid), 0);
        chk("rst2_evt", int'(bus.evt_count), 0);
        chk("rst2_data", int'(bus.rd_data), 0);
        pulse();
        chk("rst2_ts", int'(bus.rd_data), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
